// File: rtl/keypad_emulator.sv
`timescale 1ns/1ps
// keypad_emulator: replays queued keycodes as timed, optionally bouncing 4x4 keypad contact closures
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cmd_valid, cmd_key, cmd_ready  : keycode queue push handshake
//   rows                           : active-low row scan from the keypad scanner
//   cols                           : active-low column sense back to the scanner (4'b1111 when open)
//   busy, pressed, done            : sequence/queue activity, contact state, end-of-sequence pulse
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 2048,
    parameter int GAP_CYCLES    = 2048,
    parameter int BOUNCE_CYCLES = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       busy,
    output logic       pressed,
    output logic       done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BNC_M1  = CNT_W'(BOUNCE_CYCLES > 0 ? BOUNCE_CYCLES - 1 : 0);
    localparam bit BOUNCE = BOUNCE_CYCLES > 0;

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             pressed_d;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       key_row, key_col;
    logic             full, empty, push, pop, last;

    // {row, col} position of a keycode on the 4x4 matrix
    function automatic logic [3:0] key_map(input logic [3:0] k);
        case (k)
            4'd1:    key_map = {2'd0, 2'd0};
            4'd2:    key_map = {2'd0, 2'd1};
            4'd3:    key_map = {2'd0, 2'd2};
            4'd10:   key_map = {2'd0, 2'd3};
            4'd4:    key_map = {2'd1, 2'd0};
            4'd5:    key_map = {2'd1, 2'd1};
            4'd6:    key_map = {2'd1, 2'd2};
            4'd11:   key_map = {2'd1, 2'd3};
            4'd7:    key_map = {2'd2, 2'd0};
            4'd8:    key_map = {2'd2, 2'd1};
            4'd9:    key_map = {2'd2, 2'd2};
            4'd12:   key_map = {2'd2, 2'd3};
            4'd14:   key_map = {2'd3, 2'd0};
            4'd0:    key_map = {2'd3, 2'd1};
            4'd15:   key_map = {2'd3, 2'd2};
            default: key_map = {2'd3, 2'd3};
        endcase
    endfunction

    assign full      = count == (AW + 1)'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = state == IDLE && !empty;
    assign last      = cnt == '0;
    assign busy      = state != IDLE || !empty;
    assign done      = state == GAP && last;
    // Passive switch: the closed contact shorts the selected row onto its column with no latency.
    assign cols      = (pressed && !rows[key_row]) ? ~(4'b0001 << key_col) : 4'b1111;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            key_row <= '0;
            key_col <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (pop) {key_row, key_col} <= key_map(mem[rd_ptr]);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pressed <= pressed_d;
        end
    end

    // cnt holds the cycles remaining in the current phase minus one; pressed_d is next cycle's contact.
    always_comb begin
        state_d   = state;
        cnt_d     = last ? cnt : cnt - CNT_W'(1);
        pressed_d = pressed;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_d   = BOUNCE ? BOUNCE_IN : HOLD;
                    cnt_d     = BOUNCE ? BNC_M1 : HOLD_M1;
                    pressed_d = 1'b1;
                end
            end
            BOUNCE_IN: begin
                state_d   = last ? HOLD : BOUNCE_IN;
                cnt_d     = last ? HOLD_M1 : cnt_d;
                pressed_d = last ? 1'b1 : !pressed;
            end
            HOLD: begin
                state_d   = !last ? HOLD : (BOUNCE ? BOUNCE_OUT : GAP);
                cnt_d     = !last ? cnt_d : (BOUNCE ? BNC_M1 : GAP_M1);
                pressed_d = !last;
            end
            BOUNCE_OUT: begin
                state_d   = last ? GAP : BOUNCE_OUT;
                cnt_d     = last ? GAP_M1 : cnt_d;
                pressed_d = last ? 1'b0 : !pressed;
            end
            GAP: begin
                state_d   = last ? IDLE : GAP;
                pressed_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                pressed_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_emulator.sv
`timescale 1ns/1ps
// tb_keypad_emulator: two emulators (no bounce / 3-cycle bounce) against a sequence-offset reference model
module tb_keypad_emulator;
    localparam int H = 8;
    localparam int G = 4;
    localparam int BN [2] = '{0, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [1:0] ready, busy, pressed, done;
    logic [3:0] key [2];
    logic [3:0] rows [2];
    logic [3:0] cols [2];
    int n_pass = 0, n_chk = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(0), .FIFO_DEPTH(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid[0]), .cmd_key(key[0]), .cmd_ready(ready[0]),
        .rows(rows[0]), .cols(cols[0]), .busy(busy[0]), .pressed(pressed[0]), .done(done[0]));

    keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(3), .FIFO_DEPTH(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid[1]), .cmd_key(key[1]), .cmd_ready(ready[1]),
        .rows(rows[1]), .cols(cols[1]), .busy(busy[1]), .pressed(pressed[1]), .done(done[1]));

    task automatic chk(string nm, int d, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[dut%0d] got %0h want %0h at %0t", nm, d, act, exp, $time);
    endtask

    // Reference model: a queue plus the offset into the active key's press/release/gap timeline.
    int mq [2][4];
    int mh [2] = '{0, 0};
    int mn [2] = '{0, 0};
    bit mact [2] = '{0, 0};
    int mkey [2] = '{0, 0};
    int moff [2] = '{0, 0};

    function automatic int seq_len(int d);
        return 2 * BN[d] + H + G;
    endfunction

    function automatic bit closed(int b, int o);
        if (o < b) return o % 2 == 0;
        if (o < b + H) return 1'b1;
        if (o < 2 * b + H) return (o - b - H) % 2 == 1;
        return 1'b0;
    endfunction

    function automatic void pos(int k, output int r, output int c);
        int lay [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (lay[i][j] == k) begin
                    r = i;
                    c = j;
                end
    endfunction

    always @(posedge clk or negedge rst_n)
        for (int d = 0; d < 2; d++) begin
            bit psh;
            psh = valid[d] && mn[d] < 4;
            if (!rst_n) begin
                mh[d] = 0; mn[d] = 0; mact[d] = 0; moff[d] = 0;
            end else begin
                if (mact[d]) begin
                    moff[d]++;
                    if (moff[d] == seq_len(d)) mact[d] = 0;
                end else if (mn[d] > 0) begin
                    mkey[d] = mq[d][mh[d]];
                    mh[d] = (mh[d] + 1) % 4;
                    mn[d]--;
                    mact[d] = 1;
                    moff[d] = 0;
                end
                if (psh) begin
                    mq[d][(mh[d] + mn[d]) % 4] = int'(key[d]);
                    mn[d]++;
                end
            end
        end

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            int r, c;
            bit ep;
            logic [3:0] ec;
            pos(mkey[d], r, c);
            ep = mact[d] && closed(BN[d], moff[d]);
            ec = (ep && !rows[d][r]) ? ~(4'b0001 << c) : 4'b1111;
            chk("cols", d, int'(cols[d]), int'(ec));
            chk("pressed", d, int'(pressed[d]), int'(ep));
            chk("busy", d, int'(busy[d]), int'(mact[d] || mn[d] > 0));
            chk("ready", d, int'(ready[d]), int'(mn[d] < 4));
            chk("done", d, int'(done[d]), int'(mact[d] && moff[d] == seq_len(d) - 1));
        end

    // Rising edges of pressed on dut0: cycle number and cols seen on that cycle.
    int cyc = 0;
    int mon_n = 0;
    int mon_t [32];
    logic [3:0] mon_c [32];
    bit was0 = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (pressed[0] && !was0 && mon_n < 32) begin
            mon_t[mon_n] = cyc;
            mon_c[mon_n] = cols[0];
            mon_n++;
        end
        was0 = pressed[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int d, int k, output int w);
        w = 0;
        valid[d] = 1'b1;
        key[d] = 4'(k);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready[d]) break;
            w++;
            tick();
        end
        if (w == 100) chk("push_timeout", d, w, 0);
        tick();
        valid[d] = 1'b0;
    endtask

    task automatic drain(int d);
        for (int i = 0; i < 400 && busy[d]; i++) tick();
        chk("drain_idle", d, int'(busy[d]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, nlow, nbad, ndone, rise, dn, first_low, st;
        int t3 [6] = '{9, 1, 2, 3, 4, 6};
        logic [3:0] t3c [6] = '{4'b1011, 4'b1110, 4'b1101, 4'b1011, 4'b1110, 4'b1011};
        logic [14:0] cap;
        key = '{4'd0, 4'd0};
        rows = '{4'hF, 4'hF};
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cols", 0, int'(cols[0]), 4'hF);
        chk("reset_ready", 0, int'(ready[0]), 1);
        tick();

        // Single key 5 with row 1 driven low.
        rows[0] = 4'b1101;
        push(0, 5, w);
        nlow = 0; ndone = 0; rise = -1; dn = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cols[0] == 4'b1101) nlow++;
            if (pressed[0] && rise < 0) rise = i;
            if (done[0]) begin ndone++; dn = i; end
            tick();
        end
        chk("t1_low_cycles", 0, nlow, 8);
        chk("t1_done_pulses", 0, ndone, 1);
        chk("t1_done_after_rise", 0, dn - rise, 11);

        // Key 'D' against a rotating row scan.
        push(0, 13, w);
        nlow = 0; nbad = 0;
        for (int i = 0; i < 40; i++) begin
            rows[0] = ~(4'b0001 << (i % 4));
            @(negedge clk);
            if (cols[0] == 4'b0111) begin
                nlow++;
                if (rows[0] != 4'b0111) nbad++;
            end else if (cols[0] != 4'hF) nbad++;
            tick();
        end
        chk("t2_low_cycles", 0, nlow, 2);
        chk("t2_bad_cycles", 0, nbad, 0);

        // Back-to-back pushes fill the queue behind an active key.
        rows[0] = 4'b0000;
        mon_n = 0;
        first_low = -1;
        for (int j = 0; j < 6; j++) begin
            push(0, t3[j], w);
            if (w > 0 && first_low < 0) first_low = j;
        end
        drain(0);
        chk("t3_first_blocked", 0, first_low, 5);
        chk("t3_rises", 0, mon_n, 6);
        for (int j = 0; j < 6 && j < mon_n; j++) chk($sformatf("t3_cols_%0d", j), 0, int'(mon_c[j]), int'(t3c[j]));
        for (int j = 1; j < 6 && j < mon_n; j++) chk($sformatf("t3_spacing_%0d", j), 0, mon_t[j] - mon_t[j-1], 13);

        // Contact bounce on the second emulator.
        rows[1] = 4'b0111;
        push(1, 0, w);
        cap = '0; st = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (st < 0 && !cols[1][1]) st = i;
            if (st >= 0 && i - st < 15) cap[i - st] = cols[1][1];
            tick();
        end
        chk("t4_bounce_seq", 1, int'(cap), 15'h6802);

        // Push/pop on the same cycle with three keys queued.
        mon_n = 0;
        push(0, 7, w); push(0, 8, w); push(0, 9, w); push(0, 5, w);
        for (int i = 0; i < 50 && !done[0]; i++) begin @(negedge clk); if (!done[0]) tick(); end
        chk("t6_done_seen", 0, int'(done[0]), 1);
        tick();
        valid[0] = 1'b1;
        key[0] = 4'd2;
        @(negedge clk);
        chk("t6_ready_at_pop", 0, int'(ready[0]), 1);
        tick();
        valid[0] = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", 0, int'(ready[0]), 1);
        drain(0);
        chk("t6_rises", 0, mon_n, 5);

        // Asynchronous reset in the middle of a hold.
        rows[0] = 4'b1101;
        push(0, 5, w); push(0, 7, w); push(0, 8, w);
        for (int i = 0; i < 50 && !pressed[0]; i++) tick();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cols", 0, int'(cols[0]), 4'hF);
        chk("t5_pressed", 0, int'(pressed[0]), 0);
        chk("t5_busy", 0, int'(busy[0]), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_n = 0;
        repeat (60) tick();
        chk("t5_no_replay", 0, mon_n, 0);

        // Randomized traffic on both emulators.
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                valid[d] = $urandom_range(0, 3) == 0;
                key[d] = 4'($urandom_range(0, 15));
                rows[d] = $urandom_range(0, 3) != 0 ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            end
            tick();
        end
        valid = 2'b00;
        drain(0);
        drain(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
